// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver with per-frame input snapshot,
// anti-ghost guard cycle and per-digit blinking.
module seg7_scan_driver #(
   parameter int DIGITS     = 8,
   parameter int SLOT_TICKS = 2,
   parameter int GUARD      = 1,
   parameter int BLINK_HALF = 500
) (
   input  logic                  clk_1khz,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     an_n,
   output logic [2:0]            digit_idx,
   output logic                  frame_start
);

   localparam int SW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_TICKS - 1);
   localparam logic [2:0]    DIG_LAST   = 3'(DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   logic [SW-1:0]         slot_cnt, slot_nxt;
   logic [2:0]            dig_nxt;
   logic [4*DIGITS-1:0]   snap, snap_nxt;
   logic [DIGITS-1:0]     dp_snap, dp_snap_nxt;
   logic [DIGITS-1:0]     blk_snap, blk_snap_nxt;
   logic [BW-1:0]         blink_cnt, blink_nxt;
   logic                  phase, phase_nxt;
   logic                  enter0;
   logic [3:0]            nib;
   logic [6:0]            seg_d;
   logic                  dp_d;
   logic [DIGITS-1:0]     an_d;
   logic                  blank;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h40;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Outputs are computed from next-state values so they register on the
   // same edge as the counters and always match digit_idx/slot.
   always_comb begin
      slot_nxt = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
      dig_nxt  = digit_idx;
      if (slot_cnt == SLOT_LAST)
         dig_nxt = (digit_idx == DIG_LAST) ? 3'd0 : digit_idx + 3'd1;
      enter0 = (slot_nxt == '0) && (dig_nxt == 3'd0);

      snap_nxt     = enter0 ? data_in    : snap;
      dp_snap_nxt  = enter0 ? dp_in      : dp_snap;
      blk_snap_nxt = enter0 ? blink_mask : blk_snap;

      blink_nxt = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      phase_nxt = (blink_cnt == BLINK_LAST) ? ~phase : phase;

      nib   = snap_nxt[{dig_nxt, 2'b00} +: 4];
      blank = phase_nxt && blk_snap_nxt[dig_nxt];
      for (int i = 0; i < DIGITS; i++)
         an_d[i] = (dig_nxt != 3'(i));
      seg_d = blank ? 7'h7F : ~decode(nib);
      dp_d  = blank ? 1'b1  : ~dp_snap_nxt[dig_nxt];
      if (GUARD != 0 && slot_nxt == '0) begin
         an_d  = '1;
         seg_d = 7'h7F;
         dp_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_1khz or posedge rst) begin
      if (rst) begin
         slot_cnt    <= SLOT_LAST;
         digit_idx   <= DIG_LAST;
         snap        <= '1;
         dp_snap     <= '0;
         blk_snap    <= '0;
         blink_cnt   <= '0;
         phase       <= 1'b0;
         seg_n       <= 7'h7F;
         dp_n        <= 1'b1;
         an_n        <= '1;
         frame_start <= 1'b0;
      end else begin
         slot_cnt    <= slot_nxt;
         digit_idx   <= dig_nxt;
         snap        <= snap_nxt;
         dp_snap     <= dp_snap_nxt;
         blk_snap    <= blk_snap_nxt;
         blink_cnt   <= blink_nxt;
         phase       <= phase_nxt;
         seg_n       <= seg_d;
         dp_n        <= dp_d;
         an_n        <= an_d;
         frame_start <= enter0;
      end
   end

endmodule
